mem_arbiter: RTL and testbench

Two-master memory arbiter sitting directly upstream of the RAM model. It accepts one-cycle request pulses from the instruction-fetch and data ports and buffers one pending request per master. It issues one request at a time to the RAM as a one-cycle `mem_valid` pulse and routes the RAM's `mem_ready` pulse back to the owning master. A watchdog converts a missing response into an error response.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared memory-bus types and arbiter constants
package mem_arbiter_pkg;

   localparam int arb_timeout = 64;

   typedef struct packed {
      logic        mem_valid;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic        mem_error;
      logic [31:0] mem_rdata;
   } mem_out_type;

   typedef enum logic {IDLE, WAIT} arb_state_type;
   typedef enum logic {IMEM, DMEM} arb_master_type;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin memory arbiter with response watchdog
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int timeout = arb_timeout
) (
   input  logic        reset,
   input  logic        clock,
   input  mem_in_type  imem_in,
   output mem_out_type imem_out,
   input  mem_in_type  dmem_in,
   output mem_out_type dmem_out,
   output mem_in_type  ram_in,
   input  mem_out_type ram_out
);

   localparam logic [15:0] timeout_m1 = 16'(timeout - 1);

   function automatic arb_master_type choose(input logic i_cand, input logic d_cand,
                                             input arb_master_type last);
      if (i_cand && d_cand) return (last == DMEM) ? IMEM : DMEM;
      else if (i_cand)      return IMEM;
      else                  return DMEM;
   endfunction

   arb_state_type  state, state_n;
   arb_master_type owner, last_grant, grant;
   logic           i_pend, d_pend, i_cand, d_cand, i_load, d_load;
   mem_in_type     i_req, d_req, i_sel, d_sel, grant_req;
   logic [15:0]    wait_cnt;
   logic           issue, done_ready, done_timeout, resp_en;
   mem_out_type    resp;

   // A pending entry takes precedence over a same-cycle pulse, which is then dropped.
   always_comb begin
      i_sel        = i_pend ? i_req : imem_in;
      d_sel        = d_pend ? d_req : dmem_in;
      i_cand       = i_pend | imem_in.mem_valid;
      d_cand       = d_pend | dmem_in.mem_valid;
      grant        = choose(i_cand, d_cand, last_grant);
      grant_req    = (grant == IMEM) ? i_sel : d_sel;
      state_n      = state;
      issue        = 1'b0;
      done_ready   = 1'b0;
      done_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (i_cand || d_cand) begin
               issue   = 1'b1;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (ram_out.mem_ready) begin
               done_ready = 1'b1;
               state_n    = IDLE;
            end else if (wait_cnt == timeout_m1) begin
               done_timeout = 1'b1;
               state_n      = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      resp_en = done_ready | done_timeout;
      resp    = '0;
      if (done_ready) begin
         resp = ram_out;
      end else if (done_timeout) begin
         resp.mem_ready = 1'b1;
         resp.mem_error = 1'b1;
      end
      i_load = imem_in.mem_valid && !i_pend && !(state == WAIT && owner == IMEM)
               && !(issue && grant == IMEM);
      d_load = dmem_in.mem_valid && !d_pend && !(state == WAIT && owner == DMEM)
               && !(issue && grant == DMEM);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= IMEM;
         last_grant <= DMEM;
         i_pend     <= 1'b0;
         d_pend     <= 1'b0;
         i_req      <= '0;
         d_req      <= '0;
         wait_cnt   <= '0;
         ram_in     <= '0;
         imem_out   <= '0;
         dmem_out   <= '0;
      end else begin
         state    <= state_n;
         ram_in   <= issue ? grant_req : '0;
         imem_out <= (resp_en && owner == IMEM) ? resp : '0;
         dmem_out <= (resp_en && owner == DMEM) ? resp : '0;

         if (issue) begin
            owner      <= grant;
            last_grant <= grant;
            wait_cnt   <= '0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
         end

         if (issue && grant == IMEM) begin
            i_pend <= 1'b0;
         end else if (i_load) begin
            i_pend <= 1'b1;
            i_req  <= imem_in;
         end

         if (issue && grant == DMEM) begin
            d_pend <= 1'b0;
         end else if (d_load) begin
            d_pend <= 1'b1;
            d_req  <= dmem_in;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with RAM model and scoreboard
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int TO = 8;

   logic        reset = 1'b0;
   logic        clock = 1'b0;
   mem_in_type  imem_in, dmem_in, ram_in;
   mem_out_type imem_out, dmem_out, ram_out;

   mem_arbiter #(.timeout(TO)) dut (
      .reset    (reset),
      .clock    (clock),
      .imem_in  (imem_in),
      .imem_out (imem_out),
      .dmem_in  (dmem_in),
      .dmem_out (dmem_out),
      .ram_in   (ram_in),
      .ram_out  (ram_out)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ram_lat = 2;
   int          ram_cnt = 0;
   logic [31:0] ram_data = '0;
   logic [31:0] mem    [0:31];
   logic [31:0] shadow [0:31];
   logic        i_busy, d_busy, prev_rdy;
   logic [31:0] i_exp, d_exp, wd;
   logic [3:0]  ws;
   int          idx;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at the falling edge, clear pulses, advance the RAM model.
   task automatic step();
      @(negedge clock);
      cyc++;
      imem_in = '0;
      dmem_in = '0;
      ram_out = '0;
      if (ram_cnt > 0) begin
         ram_cnt--;
         if (ram_cnt == 0) begin
            ram_out.mem_ready = 1'b1;
            ram_out.mem_rdata = ram_data;
         end
      end
      if (ram_in.mem_valid) begin
         for (int b = 0; b < 4; b++)
            if (ram_in.mem_wstrb[b])
               mem[ram_in.mem_addr[6:2]][8*b +: 8] = ram_in.mem_wdata[8*b +: 8];
         ram_data = mem[ram_in.mem_addr[6:2]];
         if (ram_lat > 0) ram_cnt = ram_lat;
      end
   endtask

   task automatic pulse_i(input logic [31:0] a);
      imem_in = '{mem_valid: 1'b1, mem_addr: a, mem_wdata: 32'h0, mem_wstrb: 4'h0};
   endtask

   task automatic pulse_d(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      dmem_in = '{mem_valid: 1'b1, mem_addr: a, mem_wdata: d, mem_wstrb: s};
   endtask

   task automatic take_resp();
      if (imem_out.mem_ready) begin
         check("rnd_imem_owed", 72'(i_busy), 72'(1));
         check("rnd_imem_rdata", 72'(imem_out.mem_rdata), 72'(i_exp));
         check("rnd_imem_err", 72'(imem_out.mem_error), 72'(0));
         i_busy = 1'b0;
      end
      if (dmem_out.mem_ready) begin
         check("rnd_dmem_owed", 72'(d_busy), 72'(1));
         check("rnd_dmem_rdata", 72'(dmem_out.mem_rdata), 72'(d_exp));
         check("rnd_dmem_err", 72'(dmem_out.mem_error), 72'(0));
         d_busy = 1'b0;
      end
   endtask

   initial begin
      imem_in = '0;
      dmem_in = '0;
      ram_out = '0;
      for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE0000 + 32'(i) * 32'h111;
      mem[16] = 32'hDEADBEEF;

      // reset state
      repeat (3) step();
      check("rst_ram_in", 72'(ram_in), 72'(0));
      check("rst_imem_out", 72'(imem_out), 72'(0));
      check("rst_dmem_out", 72'(dmem_out), 72'(0));
      reset = 1'b1;
      step();
      step();

      // simultaneous pulses after reset: imem first, dmem after imem response
      step();
      pulse_i(32'h44);
      pulse_d(32'h48, 32'h0, 4'h0);
      for (int k = 1; k <= 10; k++) begin
         step();
         check("tie_ram_valid", 72'(ram_in.mem_valid), 72'(k == 1 || k == 5));
         if (k == 1) check("tie_first_addr", 72'(ram_in.mem_addr), 72'(32'h44));
         if (k == 5) check("tie_second_addr", 72'(ram_in.mem_addr), 72'(32'h48));
         check("tie_imem_ready", 72'(imem_out.mem_ready), 72'(k == 4));
         check("tie_dmem_ready", 72'(dmem_out.mem_ready), 72'(k == 8));
         if (k == 4) check("tie_imem_rdata", 72'(imem_out.mem_rdata), 72'(32'hC0DE1221));
         if (k == 8) check("tie_dmem_rdata", 72'(dmem_out.mem_rdata), 72'(32'hC0DE1332));
      end

      // single imem read of 0x40
      step();
      pulse_i(32'h40);
      for (int k = 1; k <= 5; k++) begin
         step();
         check("rd_ram_valid", 72'(ram_in.mem_valid), 72'(k == 1));
         if (k == 1) check("rd_ram_addr", 72'(ram_in.mem_addr), 72'(32'h40));
         check("rd_imem_ready", 72'(imem_out.mem_ready), 72'(k == 4));
         if (k == 4) check("rd_imem_data", 72'(imem_out.mem_rdata), 72'(32'hDEADBEEF));
         if (k == 4) check("rd_imem_err", 72'(imem_out.mem_error), 72'(0));
         check("rd_dmem_quiet", 72'(dmem_out), 72'(0));
      end

      // dmem partial write then read-back
      step();
      pulse_d(32'h50, 32'h12345678, 4'b0011);
      step();
      check("wr_ram_valid", 72'(ram_in.mem_valid), 72'(1));
      check("wr_ram_addr", 72'(ram_in.mem_addr), 72'(32'h50));
      check("wr_ram_wdata", 72'(ram_in.mem_wdata), 72'(32'h12345678));
      check("wr_ram_wstrb", 72'(ram_in.mem_wstrb), 72'(4'b0011));
      step();
      check("wr_ram_once", 72'(ram_in.mem_valid), 72'(0));
      repeat (2) step();
      check("wr_dmem_ready", 72'(dmem_out.mem_ready), 72'(1));
      step();
      pulse_d(32'h50, 32'h0, 4'h0);
      repeat (4) step();
      check("rb_dmem_ready", 72'(dmem_out.mem_ready), 72'(1));
      check("rb_dmem_rdata", 72'(dmem_out.mem_rdata), 72'(32'hC0DE5678));

      // slave silent: error response TO cycles after issue, late ready ignored
      ram_lat = 0;
      step();
      pulse_i(32'h4);
      for (int k = 1; k <= 14; k++) begin
         step();
         check("to_imem_ready", 72'(imem_out.mem_ready), 72'(k == 9));
         if (k == 9) check("to_imem_err", 72'(imem_out.mem_error), 72'(1));
         if (k == 9) check("to_imem_rdata", 72'(imem_out.mem_rdata), 72'(0));
         check("to_dmem_quiet", 72'(dmem_out), 72'(0));
         if (k >= 2) check("to_no_reissue", 72'(ram_in.mem_valid), 72'(0));
         if (k == 12) begin
            ram_out.mem_ready = 1'b1;
            ram_out.mem_rdata = 32'hBAD0BAD0;
         end
      end

      // ready in the timeout cycle: data wins
      ram_lat = TO - 1;
      step();
      pulse_i(32'h8);
      for (int k = 1; k <= 10; k++) begin
         step();
         check("co_imem_ready", 72'(imem_out.mem_ready), 72'(k == 9));
         if (k == 9) check("co_imem_err", 72'(imem_out.mem_error), 72'(0));
         if (k == 9) check("co_imem_rdata", 72'(imem_out.mem_rdata), 72'(32'hC0DE0222));
      end

      // reset two cycles into WAIT
      ram_lat = 4;
      step();
      pulse_i(32'hC);
      step();
      step();
      reset = 1'b0;
      #1;
      check("mr_ram_in", 72'(ram_in), 72'(0));
      check("mr_imem_out", 72'(imem_out), 72'(0));
      check("mr_dmem_out", 72'(dmem_out), 72'(0));
      step();
      reset = 1'b1;
      repeat (3) step();
      check("mr_late_imem", 72'(imem_out), 72'(0));
      check("mr_late_dmem", 72'(dmem_out), 72'(0));
      check("mr_late_ram", 72'(ram_in), 72'(0));
      step();
      pulse_i(32'h10);
      pulse_d(32'h54, 32'h0, 4'h0);
      step();
      check("mr_tie_valid", 72'(ram_in.mem_valid), 72'(1));
      check("mr_tie_addr", 72'(ram_in.mem_addr), 72'(32'h10));
      repeat (12) step();

      // randomized traffic against a scoreboard
      for (int i = 0; i < 32; i++) shadow[i] = mem[i];
      i_busy = 1'b0;
      d_busy = 1'b0;
      for (int n = 0; n < 400; n++) begin
         prev_rdy = ram_out.mem_ready;
         ram_lat  = int'($urandom_range(1, 5));
         step();
         check("rnd_resp_count", 72'(32'(imem_out.mem_ready) + 32'(dmem_out.mem_ready)),
               72'(prev_rdy));
         take_resp();
         if (!i_busy && $urandom_range(0, 3) == 0) begin
            idx = int'($urandom_range(0, 15));
            pulse_i(32'(idx * 4));
            i_exp  = shadow[idx];
            i_busy = 1'b1;
         end
         if (!d_busy && $urandom_range(0, 3) == 0) begin
            idx = int'($urandom_range(16, 31));
            if ($urandom_range(0, 1) == 1) begin
               wd = $urandom;
               ws = 4'($urandom_range(1, 15));
               for (int b = 0; b < 4; b++)
                  if (ws[b]) shadow[idx][8*b +: 8] = wd[8*b +: 8];
               pulse_d(32'(idx * 4), wd, ws);
            end else begin
               pulse_d(32'(idx * 4), 32'h0, 4'h0);
            end
            d_exp  = shadow[idx];
            d_busy = 1'b1;
         end
      end
      for (int n = 0; n < 40 && (i_busy || d_busy); n++) begin
         step();
         take_resp();
      end
      check("drain_imem", 72'(i_busy), 72'(0));
      check("drain_dmem", 72'(d_busy), 72'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
